// File: rtl/serial_pattern_pkg.sv
// serial_pattern_pkg: shared types and helpers for the serial pattern transmitter
package serial_pattern_pkg;
  typedef enum logic {IDLE, SHIFT} state_e;
  function automatic int run_cnt_w(input int run_len);
    return $clog2(run_len + 1);
  endfunction
  function automatic int len_clamp(input int len, input int max_len);
    return len > max_len ? max_len : len;
  endfunction
endpackage

// File: rtl/run_tracker.sv
// run_tracker: run-length history of a serial line and the non-resetting run-then-flip detector output
module run_tracker
  import serial_pattern_pkg::*;
#(
  parameter int   RUN_LEN    = 3,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  output logic exp_detect
);
  localparam int CNT_W = run_cnt_w(RUN_LEN);
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic last_bit_q, last_bit_d;
  always_comb begin
    run_cnt_d  = bit_in != last_bit_q ? CNT_W'(1) :
                 run_cnt_q == CNT_W'(RUN_LEN) ? run_cnt_q : run_cnt_q + CNT_W'(1);
    last_bit_d = bit_in;
    exp_detect = run_cnt_q == CNT_W'(RUN_LEN) && bit_in != last_bit_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_q  <= '0;
      last_bit_q <= IDLE_LEVEL;
    end else begin
      run_cnt_q  <= run_cnt_d;
      last_bit_q <= last_bit_d;
    end
  end
endmodule

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: MSB-first frame serializer with a golden run-then-flip detector output
module serial_pattern_tx
  import serial_pattern_pkg::*;
#(
  parameter int   DATA_W     = 16,
  parameter int   LEN_W      = $clog2(DATA_W + 1),
  parameter int   RUN_LEN    = 3,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [LEN_W-1:0]  tx_len,
  output logic              d_out,
  output logic              busy,
  output logic              done,
  output logic              exp_detect
);
  state_e state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d, frame;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_l;
  logic d_out_q, d_out_d;
  logic last, accept;
  always_comb begin
    len_l    = LEN_W'(len_clamp(int'(tx_len), DATA_W));
    // left-justify so the first frame bit sits in the MSB
    frame    = tx_data << (DATA_W - int'(len_l));
    last     = state_q == SHIFT && cnt_q == LEN_W'(1);
    tx_ready = !rst && (state_q == IDLE || last);
    accept   = tx_valid && tx_ready;
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    d_out_d  = d_out_q;
    if (state_q == SHIFT) begin
      state_d = last ? IDLE : SHIFT;
      d_out_d = last ? IDLE_LEVEL : sr_q[DATA_W-1];
      sr_d    = sr_q << 1;
      cnt_d   = cnt_q - LEN_W'(1);
    end
    if (accept && len_l != '0) begin
      state_d = SHIFT;
      d_out_d = frame[DATA_W-1];
      sr_d    = frame << 1;
      cnt_d   = len_l;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      d_out_q <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      d_out_q <= d_out_d;
    end
  end
  assign d_out = d_out_q;
  assign busy  = state_q == SHIFT;
  assign done  = last;
  run_tracker #(.RUN_LEN(RUN_LEN), .IDLE_LEVEL(IDLE_LEVEL)) u_run (
    .clk(clk),
    .rst(rst),
    .bit_in(d_out_q),
    .exp_detect(exp_detect)
  );
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: queue-based line model plus directed and random frames for serial_pattern_tx
module tb_serial_pattern_tx;
  localparam int DW = 16;
  localparam int LW = 5;
  localparam int RL = 3;
  logic clk = 0, rst = 1, tx_valid = 0;
  logic tx_ready, d_out, busy, done, exp_detect;
  logic [DW-1:0] tx_data = '0;
  logic [LW-1:0] tx_len = '0;
  int checks = 0, passed = 0;
  int acc_cnt = 0, done_cnt = 0;
  bit armed = 0;
  bit q_bits[$], q_last[$], hist[$];

  serial_pattern_tx #(.DATA_W(DW), .LEN_W(LW), .RUN_LEN(RL), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_len(tx_len), .d_out(d_out), .busy(busy), .done(done), .exp_detect(exp_detect)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  function automatic bit m_dout();
    return q_bits.size() != 0 ? q_bits[0] : 1'b0;
  endfunction

  // detector fires when the last RL line bits were all equal and the current bit differs
  function automatic bit m_exp();
    if (hist.size() < RL) return 1'b0;
    foreach (hist[i]) if (hist[i] != hist[0]) return 1'b0;
    return hist[0] != m_dout();
  endfunction

  always @(posedge clk) begin : model
    bit rdy;
    int len;
    if (rst) begin
      q_bits.delete();
      q_last.delete();
      hist.delete();
      armed = 1;
    end else if (armed) begin
      rdy = q_bits.size() <= 1;
      hist.push_back(m_dout());
      if (hist.size() > RL) void'(hist.pop_front());
      if (q_bits.size() != 0) begin
        void'(q_bits.pop_front());
        void'(q_last.pop_front());
      end
      if (tx_valid && rdy) begin
        len = int'(tx_len) > DW ? DW : int'(tx_len);
        for (int i = len - 1; i >= 0; i--) begin
          q_bits.push_back(tx_data[i]);
          q_last.push_back(i == 0);
        end
        if (len > 0) acc_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("d_out", d_out, m_dout());
      chk("busy", busy, q_bits.size() != 0);
      chk("done", done, q_bits.size() != 0 && q_last[0]);
      chk("tx_ready", tx_ready, !rst && q_bits.size() <= 1);
      chk("exp_detect", exp_detect, m_exp());
      if (done === 1'b1) done_cnt++;
    end
  end

  initial begin
    logic [31:0] sd, se, sn;
    int a0, d0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_d_out", d_out, 0);
      chk("idle_busy", busy, 0);
      chk("idle_ready", tx_ready, 1);
      chk("idle_exp", exp_detect, 0);
      if (i == 3) chk("run_cnt_sat", 32'(dut.u_run.run_cnt_q), 3);
      @(posedge clk); #1;
    end
    tx_valid = 1; tx_data = 16'h000E; tx_len = 4;
    @(posedge clk); #1 tx_valid = 0;
    sd = 0; se = 0; sn = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sd = {sd[30:0], d_out}; se = {se[30:0], exp_detect}; sn = {sn[30:0], done};
      @(posedge clk); #1;
    end
    chk("f1_bits", sd, 32'b1110);
    chk("f1_exp", se, 32'b1001);
    chk("f1_done", sn, 32'b0001);
    @(negedge clk);
    chk("f1_after_d_out", d_out, 0);
    chk("f1_after_busy", busy, 0);
    @(posedge clk); #1;
    tx_valid = 1; tx_data = 16'h0005; tx_len = 3;
    @(posedge clk); #1 tx_data = 16'h0002; tx_len = 2;
    sd = 0; sn = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sd = {sd[30:0], d_out}; sn = {sn[30:0], done};
      if (i == 2) chk("b2b_ready_bit3", tx_ready, 1);
      @(posedge clk); #1;
      if (i == 2) tx_valid = 0;
    end
    chk("b2b_bits", sd, 32'b10110);
    chk("b2b_done", sn, 32'b00101);
    tx_valid = 1; tx_data = 16'hFFFF; tx_len = 16;
    @(posedge clk); #1 tx_valid = 0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_d_out", d_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_exp", exp_detect, 0);
    chk("rst_run_cnt", 32'(dut.u_run.run_cnt_q), 0);
    @(posedge clk); #1;
    tx_valid = 1; tx_data = 16'hFFFF; tx_len = 0;
    @(negedge clk);
    chk("len0_ready", tx_ready, 1);
    @(posedge clk); #1 tx_valid = 0;
    @(negedge clk);
    chk("len0_busy", busy, 0);
    chk("len0_done", done, 0);
    @(posedge clk); #1;
    tx_valid = 1; tx_data = 16'h8001; tx_len = 20;
    @(posedge clk); #1 tx_valid = 0;
    sd = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      sd = {sd[30:0], d_out};
      if (i == 15) begin
        chk("clamp_last_exp", exp_detect, 1);
        chk("clamp_last_done", done, 1);
      end
      @(posedge clk); #1;
    end
    chk("clamp_bits", sd, 32'h8001);
    @(negedge clk);
    chk("clamp_after_busy", busy, 0);
    @(posedge clk); #1;
    a0 = acc_cnt; d0 = done_cnt;
    repeat (2000) begin
      tx_valid = $urandom_range(0, 3) != 0;
      tx_len = LW'($urandom_range(0, 20));
      tx_data = DW'($urandom);
      @(posedge clk); #1;
    end
    tx_valid = 0;
    repeat (30) begin
      @(posedge clk); #1;
    end
    chk("frames_vs_done", done_cnt - d0, acc_cnt - a0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
